// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one variable-latency memory port between the instruction-fetch
//   port and the data port of an RV32I pipeline. Data has priority, but
//   fetch is guaranteed a grant after at most MAX_D_STREAK consecutive data
//   grants while it waits. A watchdog aborts accesses that the memory never
//   acknowledges and reports them through err.
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     if_req/if_addr        fetch request (held until if_ready)
//     if_ready/if_rdata     one-cycle fetch completion pulse + instruction
//     d_req/d_we/d_addr/    data request (held until d_ready)
//     d_wdata
//     d_ready/d_rdata       one-cycle data completion pulse + load data
//     err                   pulses with a ready when the access timed out
//     mem_req/mem_we/       memory request, held until mem_ack or abort
//     mem_addr/mem_wdata
//     mem_rdata/mem_ack     memory read data and completion strobe
//
//   Every output comes straight from a flop: the combinational block only
//   computes next-state values, so no input reaches an output in the same
//   cycle.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int              SW          = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX  = SW'(MAX_D_STREAK);
  localparam logic [15:0]     CNT_LAST    = 16'(TIMEOUT - 1);
  // A zero streak limit means fetch only wins when data is not asking.
  localparam bit              STRICT_DATA = (MAX_D_STREAK == 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic       {G_FETCH, G_DATA}        grant_t;

  state_t        r_state,  w_state;
  grant_t        r_grant,  w_grant;
  logic [SW-1:0] r_streak, w_streak;
  logic [15:0]   r_cnt,    w_cnt;

  logic          r_mem_req,   w_mem_req;
  logic          r_mem_we,    w_mem_we;
  logic [31:0]   r_mem_addr,  w_mem_addr;
  logic [31:0]   r_mem_wdata, w_mem_wdata;
  logic          r_if_ready,  w_if_ready;
  logic [31:0]   r_if_rdata,  w_if_rdata;
  logic          r_d_ready,   w_d_ready;
  logic [31:0]   r_d_rdata,   w_d_rdata;
  logic          r_err,       w_err;

  logic          w_data_wins;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_grant     <= G_DATA;
      r_streak    <= '0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ready  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_ready   <= 1'b0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_grant     <= w_grant;
      r_streak    <= w_streak;
      r_cnt       <= w_cnt;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_if_ready  <= w_if_ready;
      r_if_rdata  <= w_if_rdata;
      r_d_ready   <= w_d_ready;
      r_d_rdata   <= w_d_rdata;
      r_err       <= w_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_grant     = r_grant;
    w_streak    = r_streak;
    w_cnt       = r_cnt;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_if_rdata  = r_if_rdata;
    w_d_rdata   = r_d_rdata;
    // ready/err are pulses: they are only raised on the BUSY->RESP edge
    // and fall again when RESP is left.
    w_if_ready  = 1'b0;
    w_d_ready   = 1'b0;
    w_err       = 1'b0;

    w_data_wins = d_req && (!if_req || STRICT_DATA || (r_streak < STREAK_MAX));

    case (r_state)
      S_IDLE: begin
        if (w_data_wins) begin
          w_grant     = G_DATA;
          w_mem_req   = 1'b1;
          w_mem_we    = d_we;
          w_mem_addr  = d_addr;
          w_mem_wdata = d_wdata;
          w_cnt       = '0;
          w_state     = S_BUSY;
          // The streak only counts data grants that made fetch wait.
          if (if_req) begin
            w_streak = (r_streak == STREAK_MAX) ? r_streak : r_streak + SW'(1);
          end else begin
            w_streak = '0;
          end
        end else if (if_req) begin
          w_grant     = G_FETCH;
          w_mem_req   = 1'b1;
          w_mem_we    = 1'b0;
          w_mem_addr  = if_addr;
          w_mem_wdata = '0;
          w_cnt       = '0;
          w_streak    = '0;
          w_state     = S_BUSY;
        end
      end

      S_BUSY: begin
        if (mem_ack) begin
          // An ack in the last watchdog cycle still counts as success.
          w_mem_req = 1'b0;
          w_state   = S_RESP;
          if (r_grant == G_DATA) begin
            w_d_ready = 1'b1;
            w_d_rdata = r_mem_we ? 32'd0 : mem_rdata;
          end else begin
            w_if_ready = 1'b1;
            w_if_rdata = mem_rdata;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_mem_req = 1'b0;
          w_err     = 1'b1;
          w_state   = S_RESP;
          if (r_grant == G_DATA) begin
            w_d_ready = 1'b1;
            w_d_rdata = '0;
          end else begin
            w_if_ready = 1'b1;
            w_if_rdata = '0;
          end
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end

      // Requests are deliberately ignored here: the requester that was just
      // served may still be holding req during its ready cycle.
      S_RESP: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ready  = r_if_ready;
  assign if_rdata  = r_if_rdata;
  assign d_ready   = r_d_ready;
  assign d_rdata   = r_d_rdata;
  assign err       = r_err;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one unified, variable-latency memory port between the RV32I pipeline's instruction-fetch port and data port. It sits between the core and a single memory. Each requester uses a req/ready handshake. The pipeline's hazard logic holds the requesting stage stalled until the matching ready pulse. Data accesses have priority, with a bounded anti-starvation rule for fetch, and a watchdog aborts transactions the memory never acknowledges.

## Interface
Parameters:
- MAX_D_STREAK, 4: maximum consecutive data grants issued while fetch is waiting. 0 means strict data priority.
- TIMEOUT, 255: BUSY cycles without mem_ack before abort. Range 2..65535.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held, with if_addr, until if_ready
- if_addr  in  32  fetch word address
- if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  32  fetched instruction (registered)
- d_req  in  1  data request; held, with d_we/d_addr/d_wdata, until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ready  out  1  one-cycle pulse: data access complete
- d_rdata  out  32  load data (registered; 0 after a store)
- err  out  1  pulses with if_ready/d_ready when the access timed out
- mem_req  out  1  memory request; held until mem_ack or abort
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion strobe from memory

## Operation
- The FSM has three states: IDLE, BUSY and RESP. A grant register (FETCH/DATA) records the owner.
- IDLE:
  - Sample if_req and d_req.
  - Only d_req, or both with d_streak < MAX_D_STREAK: grant DATA.
  - Only if_req, or both with d_streak == MAX_D_STREAK: grant FETCH.
  - On a grant, latch address, we and wdata into the mem_* registers, set mem_req=1, clear the timeout counter and go to BUSY.
  - With no request, stay in IDLE.
- d_streak:
  - Increments, saturating at MAX_D_STREAK, on a DATA grant made while if_req=1.
  - Clears on any FETCH grant.
  - Clears on a DATA grant made while if_req=0.
- BUSY:
  - mem_* outputs are held stable.
  - If mem_ack: capture mem_rdata into the owner's rdata register (d_rdata=0 for a store), drop mem_req and go to RESP with err=0.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no ack, drop mem_req, zero the owner's rdata register and go to RESP with err=1.
  - mem_ack in that final cycle wins: normal completion, err=0.
- RESP:
  - Assert the owner's ready for exactly one cycle, plus err if set, then go to IDLE.
  - Requests are not sampled in RESP, so a requester still holding req is never double-granted.
- mem_ack outside BUSY is ignored.
- mem_we is 0 for every fetch.
- rdata registers of the non-owner are unchanged.
- Requester changes of addr/data while req is high are not observed after the grant cycle.

## Timing
- Reset values: FSM=IDLE, grant=DATA, d_streak=0, counter=0. All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata, err.
- Request seen in IDLE at edge N: mem_req=1 from cycle N+1.
- mem_ack in cycle M: mem_req=0 and ready=1 in cycle M+1, rdata valid in the same cycle; IDLE in cycle M+2.
- Total latency is req-to-ready = mem latency + 2 cycles. Zero-wait memory (ack in the first BUSY cycle) gives 3 cycles per access.
- A new request presented in cycle M+2 is granted at the end of M+2. There are no idle bubbles beyond RESP.
- Timeout: ready and err are asserted TIMEOUT+1 cycles after mem_req rises.
- Reset mid-transaction: all state and outputs return to reset values at the next edge. mem_req drops and no ready is pulsed. The memory sees an abandoned request.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Single fetch, zero-wait memory: if_req=1, if_addr=0x100, mem_ack in the first BUSY cycle with mem_rdata=0x00500093 -> mem_addr=0x100, mem_we=0; if_ready pulses 3 cycles after if_req with if_rdata=0x00500093; err=0.
- Store with 2 wait states: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF held for 3 BUSY cycles; d_ready pulses 5 cycles after d_req; d_rdata=0.
- Simultaneous requests with MAX_D_STREAK=4: if_req and d_req held continuously, zero-wait memory -> grant order D,D,D,D,F,D,D,D,D,F; if_ready never lost; each grant separated by exactly 3 cycles.
- Timeout with TIMEOUT=8: d_req load, memory never acks -> mem_req high exactly 8 cycles; d_ready=1, err=1, d_rdata=0 in the cycle after. Repeat with ack in the 8th BUSY cycle -> err=0, data captured.
- Reset mid-BUSY: reset=1 during the 2nd BUSY cycle of a fetch -> next cycle mem_req=0, all outputs 0, no if_ready. After release, the held if_req is re-granted normally.
- Late requester drop: requester keeps d_req=1 through the RESP cycle, then releases -> exactly one grant and one d_ready; no second mem_req.
